// File: rtl/gcd_req_pkg.sv
// Shared types and defaults for the GCD requester: FSM state encoding and
// the default operand width / WAIT timeout.
package gcd_req_pkg;

  localparam int DEF_WIDTH          = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_WAIT,
    ST_CLEAR,
    ST_RESP
  } gcd_req_state_e;

endpackage

// File: rtl/gcd_req_timer.sv
// WAIT-phase watchdog for gcd_requester: counts enabled cycles and flags expiry
// on the TIMEOUT_CYCLES-th one. Only compiled when GCD_REQ_TIMEOUT_EN is defined.
`ifdef GCD_REQ_TIMEOUT_EN
module gcd_req_timer
  import gcd_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // cnt equals the number of enabled cycles already elapsed, so expiry fires
  // during the last permitted cycle and the FSM leaves on that edge.
  assign expired = enable && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/gcd_requester.sv
// Request/response front end for a serial-load subtractive GCD core.
// Optional WAIT timeout (rsp_err) is built only with GCD_REQ_TIMEOUT_EN defined.
module gcd_requester
  import gcd_req_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  output logic             gcd_clr_n,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_err
);

  gcd_req_state_e   state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, rsp_gcd_q;
  logic             accept, zero_op, timeout_hit;

  // Computed from state directly (not from req_ready) to keep the FSM
  // combinational block free of feedback through its own outputs.
  assign accept  = req_valid && rst_n && (state == ST_IDLE);
  assign zero_op = (req_a == '0) || (req_b == '0);
  assign rsp_gcd = rsp_gcd_q;

`ifdef GCD_REQ_TIMEOUT_EN
  logic rsp_err_q;

  gcd_req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != ST_WAIT),
    .enable (state == ST_WAIT),
    .expired(timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (accept) begin
      rsp_err_q <= 1'b0;
    end else if (state == ST_WAIT && !gcd_done && timeout_hit) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign rsp_err            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output gets a default before the case statement, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    gcd_start = 1'b0;
    gcd_data  = '0;
    gcd_clr_n = rst_n;
    rsp_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = rst_n;
        if (accept) begin
          // A zero operand would make the subtractive core spin forever.
          state_nxt = zero_op ? ST_RESP : ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        gcd_start = 1'b1;
        gcd_data  = a_q;
        state_nxt = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        gcd_data  = b_q;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        gcd_data = b_q;
        if (gcd_done || timeout_hit) begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        gcd_clr_n = 1'b0;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: operand and result registers are reset because rsp_gcd and gcd_data
  // are visible at the ports and must read zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      rsp_gcd_q <= '0;
    end else begin
      if (accept) begin
        a_q <= req_a;
        b_q <= req_b;
        if (zero_op) begin
          rsp_gcd_q <= req_a | req_b;
        end
      end
      if (state == ST_WAIT) begin
        if (gcd_done) begin
          rsp_gcd_q <= gcd_result;
        end else if (timeout_hit) begin
          rsp_gcd_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench for gcd_requester: behavioural subtractive GCD core,
// table-driven directed jobs, reset/timeout sequences and randomized jobs.
module tb_gcd_requester;

  localparam int W      = 16;
  localparam int TO     = 16;
  localparam int BUDGET = 2000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready;
  logic [W-1:0] req_a, req_b;
  logic         gcd_start, gcd_clr_n, gcd_done;
  logic [W-1:0] gcd_data, gcd_result;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0] rsp_gcd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_requester #(
    .WIDTH         (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .gcd_start (gcd_start),
    .gcd_data  (gcd_data),
    .gcd_clr_n (gcd_clr_n),
    .gcd_done  (gcd_done),
    .gcd_result(gcd_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_gcd   (rsp_gcd),
    .rsp_err   (rsp_err)
  );

  // Behavioural subtractive GCD core: A loaded with start, B on the next cycle.
  logic [W-1:0] core_a, core_b;
  logic         core_load_b, core_busy, core_done, core_stuck;

  always @(posedge clk) begin
    if (!gcd_clr_n) begin
      core_a <= '0; core_b <= '0; core_load_b <= 1'b0; core_busy <= 1'b0; core_done <= 1'b0;
    end else if (gcd_start) begin
      core_a <= gcd_data; core_load_b <= 1'b1;
    end else if (core_load_b) begin
      core_b <= gcd_data; core_load_b <= 1'b0; core_busy <= 1'b1;
    end else if (core_busy && !core_stuck) begin
      if (core_b == '0) begin
        core_busy <= 1'b0; core_done <= 1'b1;
      end else if (core_a < core_b) begin
        core_a <= core_b; core_b <= core_a;
      end else begin
        core_a <= core_a - core_b;
      end
    end
  end

  assign gcd_done   = core_done;
  assign gcd_result = core_a;

  function automatic logic [W-1:0] ref_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic recover();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; core_stuck = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // One complete job from IDLE through the response handshake.
  task automatic run_job(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_gcd, input logic exp_err, input int hold);
    bit zero = (a == '0) || (b == '0);
    int cyc = 0, done_cyc = -1, clr_cyc = -1, clr_cnt = 0, wait_cnt = 0, start_cnt = 0;
    bit busy_ready = 0, unstable = 0;
    check({name, ".idle_ready"}, req_ready, 1);
    req_a = a; req_b = b; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    if (!zero) begin
      check({name, ".load_a_start"}, gcd_start, 1);
      check({name, ".load_a_data"}, gcd_data, a);
      check({name, ".load_a_ready"}, req_ready, 0);
      step();
      check({name, ".load_b_start"}, gcd_start, 0);
      check({name, ".load_b_data"}, gcd_data, b);
    end
    while (!rsp_valid && cyc < BUDGET) begin
      step();
      cyc++;
      if (req_ready) busy_ready = 1;
      if (gcd_start) start_cnt++;
      if (gcd_done && done_cyc < 0) done_cyc = cyc;
      if (!gcd_clr_n) begin
        clr_cnt++;
        clr_cyc = cyc;
      end else if (clr_cnt == 0 && !rsp_valid) begin
        wait_cnt++;
      end
    end
    if (!rsp_valid) begin
      check({name, ".response_within_budget"}, 0, 1);
      recover();
      return;
    end
    check({name, ".rsp_gcd"}, rsp_gcd, exp_gcd);
    check({name, ".rsp_err"}, rsp_err, exp_err);
    check({name, ".resp_req_ready"}, req_ready, 0);
    check({name, ".busy_req_ready"}, busy_ready, 0);
    if (zero) begin
      check({name, ".zero_direct_resp"}, cyc, 0);
      check({name, ".zero_no_start"}, gcd_start, 0);
    end else begin
      check({name, ".extra_start"}, start_cnt, 0);
      check({name, ".clr_pulses"}, clr_cnt, 1);
      check({name, ".clr_before_rsp"}, clr_cyc, cyc - 1);
      if (exp_err) check({name, ".wait_cycles"}, wait_cnt, TO);
      else         check({name, ".done_to_rsp"}, cyc - done_cyc, 2);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      if (!rsp_valid || rsp_gcd !== exp_gcd || rsp_err !== exp_err || req_ready) unstable = 1;
    end
    if (hold > 0) check({name, ".hold_stable"}, unstable, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({name, ".post_rsp_valid"}, rsp_valid, 0);
    check({name, ".post_req_ready"}, req_ready, 1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_gcd;
    int           hold;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #900us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_rsp;
    logic [W-1:0] ra, rb;
    vecs[0] = '{a: 16'd143,   b: 16'd78,    exp_gcd: 16'd13,    hold: 0};
    vecs[1] = '{a: 16'd48,    b: 16'd18,    exp_gcd: 16'd6,     hold: 20};
    vecs[2] = '{a: 16'd0,     b: 16'd7,     exp_gcd: 16'd7,     hold: 0};
    vecs[3] = '{a: 16'd9,     b: 16'd0,     exp_gcd: 16'd9,     hold: 2};
    vecs[4] = '{a: 16'd0,     b: 16'd0,     exp_gcd: 16'd0,     hold: 0};
    vecs[5] = '{a: 16'd1,     b: 16'd1,     exp_gcd: 16'd1,     hold: 1};
    vecs[6] = '{a: 16'hFFFF,  b: 16'hFFFF,  exp_gcd: 16'hFFFF,  hold: 0};
    vecs[7] = '{a: 16'hFFFF,  b: 16'd0,     exp_gcd: 16'hFFFF,  hold: 0};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; core_stuck = 1'b0;
    req_a = '0; req_b = '0;
    repeat (3) step();
    check("reset.req_ready", req_ready, 0);
    check("reset.gcd_start", gcd_start, 0);
    check("reset.gcd_data", gcd_data, 0);
    check("reset.gcd_clr_n", gcd_clr_n, 0);
    check("reset.rsp_valid", rsp_valid, 0);
    check("reset.rsp_gcd", rsp_gcd, 0);
    check("reset.rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++)
      run_job($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_gcd, 1'b0, vecs[i].hold);

    // Reset pulsed while the core is still working: job must vanish silently.
    core_stuck = 1'b1;
    saw_rsp = 0;
    req_a = 16'd143; req_b = 16'd78; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (rsp_valid) saw_rsp = 1;
    end
    rst_n = 1'b0;
    step();
    check("midjob_reset.req_ready", req_ready, 0);
    check("midjob_reset.gcd_start", gcd_start, 0);
    check("midjob_reset.gcd_clr_n", gcd_clr_n, 0);
    check("midjob_reset.rsp_gcd", rsp_gcd, 0);
    rst_n = 1'b1;
    core_stuck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) saw_rsp = 1;
      if (i < 2) step();
    end
    check("midjob_reset.no_response", saw_rsp, 0);
    run_job("after_reset", 16'd143, 16'd78, 16'd13, 1'b0, 0);

`ifdef GCD_REQ_TIMEOUT_EN
    core_stuck = 1'b1;
    run_job("timeout", 16'd143, 16'd78, 16'd0, 1'b1, 3);
    core_stuck = 1'b0;
    run_job("after_timeout", 16'd48, 16'd18, 16'd6, 1'b0, 0);
`endif

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom_range(1, 255));
      rb = W'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0) ra = '0;
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_job($sformatf("rand%0d", i), ra, rb, ref_gcd(ra, rb), 1'b0, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
